// File: rtl/mem_rf.sv
// mem_rf: parametrised single-port register-file RAM with per-byte write
// enables, a registered read port with a one-cycle valid strobe, an
// out-of-range error strobe and a hardware bulk-clear sequencer.
//
// Ports:
//   clk     - clock, all state updates on the rising edge
//   rst_n   - asynchronous active-low reset, zeroes the array and all outputs
//   cs      - chip select, qualifies every access
//   we      - 1 = write, 0 = read
//   be      - byte-lane write enables (NB bits), ignored on reads
//   addr    - word address (AW bits)
//   din     - write data (WIDTH bits)
//   clr     - one-cycle pulse that starts a bulk clear of the whole array
//   dout    - registered read data, holds between reads
//   rvalid  - one-cycle pulse, dout was loaded by the previous cycle's read
//   err     - one-cycle pulse, the previous cycle's access had addr >= DEPTH
//   busy    - high while the bulk clear is sweeping the array
module mem_rf #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int NB    = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cs,
    input  logic             we,
    input  logic [NB-1:0]    be,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] din,
    input  logic             clr,
    output logic [WIDTH-1:0] dout,
    output logic             rvalid,
    output logic             err,
    output logic             busy
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t             state_q;
    logic [AW-1:0]      ptr_q;
    logic               busy_q;
    logic [WIDTH-1:0]   dout_q;
    logic               rvalid_q;
    logic               err_q;
    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic               inRange;
    logic               accTaken;
    logic               wrEn;
    logic               rdEn;

    // When DEPTH fills the whole address space every address is legal;
    // otherwise the top few encodings are out of range.
    generate
        if (DEPTH == (1 << AW)) begin : gFullRange
            assign inRange = 1'b1;
        end else begin : gPartialRange
            assign inRange = (addr <= LAST_ADDR);
        end
    endgenerate

    // An access only counts in IDLE, and a clr pulse in the same cycle wins
    // over it, so the access is simply dropped.
    assign accTaken = (state_q == IDLE) && !clr && cs;
    assign wrEn     = accTaken && we && inRange;
    assign rdEn     = accTaken && !we && inRange;

    // Clear sequencer and read/status registers. busy is kept as its own
    // register so it rises the cycle after clr and falls the cycle after
    // the last word is cleared, giving exactly DEPTH cycles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            busy_q   <= 1'b0;
            dout_q   <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clr) begin
                        state_q <= CLEAR;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end else if (cs) begin
                        if (!inRange) begin
                            err_q <= 1'b1;
                        end else if (rdEn) begin
                            dout_q   <= mem_q[addr];
                            rvalid_q <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    if (ptr_q == LAST_ADDR) begin
                        state_q <= IDLE;
                        ptr_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ptr_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Storage array. The clear sweep and CPU writes are mutually exclusive
    // because writes are only accepted in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (state_q == CLEAR) begin
            mem_q[ptr_q] <= '0;
        end else if (wrEn) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem_q[addr][8*b +: 8] <= din[8*b +: 8];
                end
            end
        end
    end

    assign dout   = dout_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;
    assign busy   = busy_q;

endmodule

// File: doc/mem_rf.md
Name: mem_rf

Overview:
- Parametrised successor to the SoC's fixed 8x16 data memory: synchronous register-file RAM with configurable width and depth, per-byte write enables, and a registered read port with a valid strobe.
- Adds a hardware bulk-clear sequencer so software can zero the array without a system reset.
- Sits between the CPU load/store path and the data bus.

Parameters:
- WIDTH, 16, data word width in bits; must be a multiple of 8.
- DEPTH, 8, number of words; any value 2..256, not necessarily a power of two.
- AW, $clog2(DEPTH), address width.
- NB, WIDTH/8, number of byte lanes (derived; not to be overridden).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cs  input  1  chip select; an access is taken only when cs=1.
- we  input  1  1=write, 0=read (qualified by cs).
- be  input  NB  byte-lane write enables; be[i] covers din[8i+7:8i].
- addr  input  AW  word address.
- din  input  WIDTH  write data.
- clr  input  1  1-cycle pulse starting a bulk clear.
- dout  output  WIDTH  registered read data; holds its value between reads.
- rvalid  output  1  1-cycle pulse: dout updated by the read issued the previous cycle.
- err  output  1  1-cycle pulse: the access issued the previous cycle had addr >= DEPTH.
- busy  output  1  high while the bulk clear runs.

Behaviour:
- Reset (rst_n=0, async):
  - all DEPTH words = 0;
  - dout=0, rvalid=0, err=0, busy=0;
  - FSM goes to IDLE, clear pointer = 0.
  - Reset asserted mid-clear aborts the clear; the array is zero anyway.
- Write (cs=1, we=1, addr<DEPTH, busy=0):
  - at the edge, byte lane i of mem[addr] takes din lane i wherever be[i]=1; other lanes are unchanged;
  - be=0 is a legal no-op;
  - rvalid stays 0.
- Read (cs=1, we=0, addr<DEPTH, busy=0):
  - at the edge, dout <= mem[addr] and rvalid=1 for exactly one cycle;
  - latency is 1 cycle; back-to-back reads give rvalid=1 on consecutive cycles;
  - dout keeps its value while no read is taken (cs=0, writes, busy);
  - be is ignored on reads.
- Out of range (cs=1, addr>=DEPTH; only possible when DEPTH is not 2^AW):
  - a write is dropped;
  - a read leaves dout unchanged and does not assert rvalid;
  - err pulses for one cycle after the access.
- Read/write ordering: a read of the address written in the previous cycle returns the newly written data. There is only one port, so a same-cycle read and write cannot occur.
- Clear FSM:
  - IDLE: on clr=1, go to CLEAR with pointer = 0, and set busy=1 from the next cycle.
  - CLEAR: each cycle write mem[pointer] = 0 and increment pointer. When pointer = DEPTH-1 has been written, go to IDLE; busy drops the cycle after the last write.
  - A clear takes exactly DEPTH cycles of busy=1.
  - While busy=1, all cs accesses are ignored: no write, no rvalid, no err. Requesters must wait for busy=0.
  - clr asserted while busy=1 is ignored; the clear does not restart.
  - clr and cs in the same IDLE cycle: clr wins, the access is dropped, and the FSM enters CLEAR.
- No combinational path from inputs to outputs; all outputs are registered.
- The array is built from flops with an asynchronous reset. Gated clocks and latches are not used.

Test Plan:
- Reset then read: release rst_n; read addr 0..DEPTH-1 -> dout=0x0000 with rvalid=1 one cycle after each read, err=0.
- Byte-enable write: write 0xA5A5 be=11 to addr 3, then 0x3C00 be=10 to addr 3; read addr 3 -> dout=0x3CA5.
- Back-to-back traffic: write 0x1234 to addr 5; next cycle read addr 5 -> dout=0x1234; three consecutive reads of addrs 5, 0, 5 -> rvalid high three cycles, dout 0x1234, 0x0000, 0x1234; with cs=0 afterwards dout holds 0x1234.
- Bulk clear (DEPTH=8): fill all words with 0xFFFF, pulse clr -> busy high exactly 8 cycles; a write of 0x5555 to addr 2 and a second clr during busy are ignored; reads after busy drops -> all 0x0000.
- Out of range (DEPTH=6, AW=3): write 0xBEEF to addr 6 -> err pulse one cycle later, no word changes; read addr 7 -> err=1, rvalid=0, dout unchanged.
- Async reset mid-clear: fill with 0xFFFF, pulse clr, drop rst_n two cycles later for 1 ns -> busy=0 immediately, dout=0, and all reads return 0x0000 after release.
